register_file_stage: RTL and testbench

REGISTER_FILE_STAGE -- requirements
Module: register_file_stage

---
 rtl/register_file_stage.sv | 142 ++++++++++++++
 tb/tb_register_file_stage.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/register_file_stage.sv
// Register-read pipeline stage: reads two operands, registers the ALU bundle, takes ALU writeback.
// Optional same-cycle writeback forwarding is enabled by defining REGFILE_BYPASS_EN.

package InstructionSetPkg;
    localparam int DataWidth      = 16;
    localparam int ImmediateWidth = 8;

    typedef enum logic [3:0] {
        OP_NOP = 4'd0,
        OP_ADD = 4'd1,
        OP_SUB = 4'd2,
        OP_AND = 4'd3,
        OP_OR  = 4'd4,
        OP_XOR = 4'd5,
        OP_SHL = 4'd6,
        OP_SHR = 4'd7,
        OP_MOV = 4'd8,
        OP_LDI = 4'd9
    } eOperation;

    typedef struct packed {
        logic zero;
        logic negative;
        logic carry;
        logic overflow;
    } sFlags;
endpackage

module register_file_stage #(
    parameter int DataWidth      = InstructionSetPkg::DataWidth,
    parameter int ImmediateWidth = InstructionSetPkg::ImmediateWidth,
    parameter int RegCount       = 8,
    localparam int AddrWidth     = (RegCount > 1) ? $clog2(RegCount) : 1
) (
    input  logic                              Clock,
    input  logic                              nReset,
    input  logic                              InValid,
    output logic                              InReady,
    input  InstructionSetPkg::eOperation      InOperation,
    input  logic [AddrWidth-1:0]              InSrcSel,
    input  logic [AddrWidth-1:0]              InDestSel,
    input  logic [ImmediateWidth-1:0]         InImmField,
    output logic                              OutValid,
    input  logic                              OutReady,
    output InstructionSetPkg::eOperation      Operation,
    output logic signed [DataWidth-1:0]       Src,
    output logic signed [DataWidth-1:0]       Dest,
    output logic signed [ImmediateWidth-1:0]  Imm,
    output logic [AddrWidth-1:0]              DestSel,
    output InstructionSetPkg::sFlags          Flags,
    input  logic                              WbValid,
    input  logic [AddrWidth-1:0]              WbSel,
    input  logic [DataWidth-1:0]              WbData,
    input  InstructionSetPkg::sFlags          WbFlags
);

    logic signed [DataWidth-1:0] regs_r [RegCount];
    InstructionSetPkg::sFlags    flags_r;

    logic                        accept_s;
    logic                        wb_in_range_s;
    logic signed [DataWidth-1:0] src_read_s;
    logic signed [DataWidth-1:0] dest_read_s;

    assign InReady       = !OutValid || OutReady;
    assign accept_s      = InValid && InReady;
    // Writes to a non-existent register are dropped and must never be forwarded either.
    assign wb_in_range_s = ({1'b0, WbSel} < (AddrWidth + 1)'(RegCount));

    // Operand read mux with optional forwarding of the same-cycle writeback.
    always_comb begin
        src_read_s  = '0;
        dest_read_s = '0;
        for (int i = 0; i < RegCount; i++) begin
            src_read_s  = (InSrcSel  == AddrWidth'(i)) ? regs_r[i] : src_read_s;
            dest_read_s = (InDestSel == AddrWidth'(i)) ? regs_r[i] : dest_read_s;
        end
`ifdef REGFILE_BYPASS_EN
        if (WbValid && wb_in_range_s && (InSrcSel == WbSel)) begin
            src_read_s = WbData;
        end else begin
            src_read_s = src_read_s;
        end
        if (WbValid && wb_in_range_s && (InDestSel == WbSel)) begin
            dest_read_s = WbData;
        end else begin
            dest_read_s = dest_read_s;
        end
`endif
    end

`ifdef REGFILE_BYPASS_EN
    assign Flags = WbValid ? WbFlags : flags_r;
`else
    assign Flags = flags_r;
`endif

    // Register file and flag register: reset clear, then ALU writeback.
    always_ff @(posedge Clock) begin
        if (!nReset) begin
            for (int i = 0; i < RegCount; i++) begin
                regs_r[i] <= '0;
            end
            flags_r <= '0;
        end else if (WbValid) begin
            for (int i = 0; i < RegCount; i++) begin
                if (wb_in_range_s && (WbSel == AddrWidth'(i))) begin
                    regs_r[i] <= WbData;
                end else begin
                    regs_r[i] <= regs_r[i];
                end
            end
            flags_r <= WbFlags;
        end else begin
            flags_r <= flags_r;
        end
    end

    // Operand bundle register: loads on accept, holds while stalled, drains on consume.
    always_ff @(posedge Clock) begin
        if (!nReset) begin
            OutValid  <= 1'b0;
            Operation <= InstructionSetPkg::OP_NOP;
            Src       <= '0;
            Dest      <= '0;
            Imm       <= '0;
            DestSel   <= '0;
        end else if (accept_s) begin
            OutValid  <= 1'b1;
            Operation <= InOperation;
            Src       <= src_read_s;
            Dest      <= dest_read_s;
            Imm       <= InImmField;
            DestSel   <= InDestSel;
        end else if (OutValid && OutReady) begin
            OutValid  <= 1'b0;
        end else begin
            OutValid  <= OutValid;
        end
    end

endmodule

// File: tb/tb_register_file_stage.sv
// Directed bench for register_file_stage; expectations follow REGFILE_BYPASS_EN when defined.
module tb_register_file_stage;
    import InstructionSetPkg::*;

`ifdef REGFILE_BYPASS_EN
    localparam bit Bypass = 1'b1;
`else
    localparam bit Bypass = 1'b0;
`endif

    logic              Clock = 1'b0;
    logic              nReset;
    logic              InValid;
    logic              InReady;
    eOperation         InOperation;
    logic [2:0]        InSrcSel;
    logic [2:0]        InDestSel;
    logic [7:0]        InImmField;
    logic              OutValid;
    logic              OutReady;
    eOperation         Operation;
    logic signed [15:0] Src;
    logic signed [15:0] Dest;
    logic signed [7:0]  Imm;
    logic [2:0]        DestSel;
    sFlags             Flags;
    logic              WbValid;
    logic [2:0]        WbSel;
    logic [15:0]       WbData;
    sFlags             WbFlags;

    int checks = 0;
    int errors = 0;

    register_file_stage dut (
        .Clock(Clock), .nReset(nReset),
        .InValid(InValid), .InReady(InReady), .InOperation(InOperation),
        .InSrcSel(InSrcSel), .InDestSel(InDestSel), .InImmField(InImmField),
        .OutValid(OutValid), .OutReady(OutReady),
        .Operation(Operation), .Src(Src), .Dest(Dest), .Imm(Imm), .DestSel(DestSel),
        .Flags(Flags),
        .WbValid(WbValid), .WbSel(WbSel), .WbData(WbData), .WbFlags(WbFlags)
    );

    always #5 Clock = ~Clock;

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [2:0] s, input logic [2:0] d, input logic [7:0] imm,
                         input eOperation op);
        InValid     = 1'b1;
        InSrcSel    = s;
        InDestSel   = d;
        InImmField  = imm;
        InOperation = op;
    endtask

    logic [2:0]  b2b_src [4] = '{3'd3, 3'd2, 3'd0, 3'd3};
    logic [15:0] b2b_exp [4] = '{16'h5555, 16'h00FF, 16'h0000, 16'h5555};

    initial begin
        nReset = 1'b0; InValid = 1'b0; InOperation = OP_NOP; InSrcSel = 3'd0; InDestSel = 3'd0;
        InImmField = 8'h00; OutReady = 1'b1; WbValid = 1'b0; WbSel = 3'd0; WbData = 16'h0000;
        WbFlags = 4'b0000;

        // Reset
        step(); step();
        check("rst_outvalid", {31'h0, OutValid}, 32'h0);
        check("rst_flags", {28'h0, Flags}, 32'h0);
        nReset = 1'b1;
        check("rst_inready_first", {31'h0, InReady}, 32'h1);
        check("rst_outvalid_first", {31'h0, OutValid}, 32'h0);

        // Read every register after reset
        for (int i = 0; i < 8; i++) begin
            issue(3'(i), 3'(i), 8'h00, OP_NOP);
            step();
            check("rst_read_src", {16'h0, Src}, 32'h0);
            check("rst_read_dest", {16'h0, Dest}, 32'h0);
            check("rst_read_valid", {31'h0, OutValid}, 32'h1);
        end
        InValid = 1'b0;
        step();
        check("drain_valid", {31'h0, OutValid}, 32'h0);

        // Writeback r3 then read it
        WbValid = 1'b1; WbSel = 3'd3; WbData = 16'h1234; WbFlags = 4'b1010;
        #1;
        check("flags_comb_wb", {28'h0, Flags}, Bypass ? 32'hA : 32'h0);
        step();
        WbValid = 1'b0;
        check("flags_after_wb", {28'h0, Flags}, 32'hA);
        issue(3'd3, 3'd5, 8'hF5, OP_ADD);
        step();
        InValid = 1'b0;
        check("wb_read_src", {16'h0, Src}, 32'h1234);
        check("wb_read_dest", {16'h0, Dest}, 32'h0);
        check("wb_read_valid", {31'h0, OutValid}, 32'h1);
        check("wb_read_imm", {24'h0, Imm}, 32'hF5);
        check("wb_read_destsel", {29'h0, DestSel}, 32'h5);
        check("wb_read_op", {28'h0, Operation}, 32'h1);

        // Same-cycle writeback and read of r2
        WbValid = 1'b1; WbSel = 3'd2; WbData = 16'h00FF; WbFlags = 4'b0101;
        issue(3'd2, 3'd2, 8'h00, OP_SUB);
        #1;
        check("flags_comb_fwd", {28'h0, Flags}, Bypass ? 32'h5 : 32'hA);
        step();
        WbValid = 1'b0; InValid = 1'b0;
        check("fwd_src", {16'h0, Src}, Bypass ? 32'h00FF : 32'h0);
        check("fwd_dest", {16'h0, Dest}, Bypass ? 32'h00FF : 32'h0);
        check("fwd_flags", {28'h0, Flags}, 32'h5);
        issue(3'd2, 3'd3, 8'h00, OP_SUB);
        step();
        InValid = 1'b0;
        check("reread_src", {16'h0, Src}, 32'h00FF);
        check("reread_dest", {16'h0, Dest}, 32'h1234);

        // Stall: hold bundle for 3 cycles, writeback to r3 meanwhile
        issue(3'd3, 3'd2, 8'h11, OP_AND);
        step();
        check("stall_load_src", {16'h0, Src}, 32'h1234);
        OutReady = 1'b0;
        issue(3'd2, 3'd0, 8'h22, OP_OR);
        WbValid = 1'b1; WbSel = 3'd3; WbData = 16'h5555; WbFlags = 4'b0000;
        #1;
        check("stall_inready_pre", {31'h0, InReady}, 32'h0);
        for (int k = 0; k < 3; k++) begin
            step();
            WbValid = 1'b0;
            check("stall_inready", {31'h0, InReady}, 32'h0);
            check("stall_valid", {31'h0, OutValid}, 32'h1);
            check("stall_src", {16'h0, Src}, 32'h1234);
            check("stall_dest", {16'h0, Dest}, 32'h00FF);
            check("stall_imm", {24'h0, Imm}, 32'h11);
            check("stall_destsel", {29'h0, DestSel}, 32'h2);
        end
        OutReady = 1'b1;
        #1;
        check("release_inready", {31'h0, InReady}, 32'h1);
        step();
        InValid = 1'b0;
        check("release_src", {16'h0, Src}, 32'h00FF);
        check("release_dest", {16'h0, Dest}, 32'h0);
        check("release_imm", {24'h0, Imm}, 32'h22);
        check("release_destsel", {29'h0, DestSel}, 32'h0);
        check("release_op", {28'h0, Operation}, 32'h4);
        step();
        check("release_drain", {31'h0, OutValid}, 32'h0);

        // Back-to-back throughput
        for (int k = 0; k < 4; k++) begin
            issue(b2b_src[k], 3'd1, 8'(k + 1), OP_XOR);
            step();
            check("b2b_valid", {31'h0, OutValid}, 32'h1);
            check("b2b_imm", {24'h0, Imm}, 32'(k + 1));
            check("b2b_src", {16'h0, Src}, {16'h0, b2b_exp[k]});
        end
        InValid = 1'b0;
        step();
        check("b2b_drain", {31'h0, OutValid}, 32'h0);

        // Reset while a bundle is held, with a competing writeback
        OutReady = 1'b0;
        issue(3'd3, 3'd3, 8'h7E, OP_MOV);
        step();
        InValid = 1'b0;
        check("held_valid", {31'h0, OutValid}, 32'h1);
        check("held_src", {16'h0, Src}, 32'h5555);
        nReset = 1'b0;
        WbValid = 1'b1; WbSel = 3'd3; WbData = 16'h7777; WbFlags = 4'b1111;
        step();
        WbValid = 1'b0;
        check("rst2_valid", {31'h0, OutValid}, 32'h0);
        check("rst2_src", {16'h0, Src}, 32'h0);
        check("rst2_imm", {24'h0, Imm}, 32'h0);
        check("rst2_op", {28'h0, Operation}, 32'h0);
        check("rst2_flags", {28'h0, Flags}, 32'h0);
        nReset = 1'b1;
        OutReady = 1'b1;
        check("rst2_inready", {31'h0, InReady}, 32'h1);
        issue(3'd3, 3'd2, 8'h00, OP_NOP);
        step();
        InValid = 1'b0;
        check("rst2_r3", {16'h0, Src}, 32'h0);
        check("rst2_r2", {16'h0, Dest}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
